// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared opcodes, error code default and FSM encodings for the ALU command controller.
package alu_cmd_ctrl_pkg;

  localparam logic [3:0] OP_AND      = 4'h0;
  localparam logic [3:0] OP_OR       = 4'h1;
  localparam logic [3:0] OP_ADD      = 4'h2;
  localparam logic [3:0] OP_SUB      = 4'h3;
  localparam logic [3:0] OP_SHL      = 4'h4;
  localparam logic [3:0] OP_SHR      = 4'h5;
  localparam logic [3:0] OP_ASR      = 4'h6;
  localparam logic [3:0] OP_XOR      = 4'h7;
  localparam logic [3:0] OP_EQ       = 4'h8;
  localparam logic [3:0] OP_GE       = 4'h9;
  localparam logic [3:0] OP_LT       = 4'hA;
  localparam logic [3:0] OP_RSVD_MIN = 4'hB;

  localparam logic [7:0] ERR_CODE_DEFAULT = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_ctrl_err_check.sv
// Combinational pre-check of a command: ADD carry-out / SUB borrow and reserved-opcode detect.
module alu_err_check
  import alu_cmd_ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       err,
  output logic       reserved
);

  logic [8:0] sum;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign err      = ((op == OP_ADD) && sum[8]) || ((op == OP_SUB) && (a < b));
  assign reserved = (op >= OP_RSVD_MIN);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Sequencing initiator for the 8-bit combinational ALU: command in, operands held, result out.
// Optional accumulator chaining is enabled by defining ACC_CHAIN_EN.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int unsigned ALU_LAT  = 1,
  parameter logic [7:0]  ERR_CODE = ERR_CODE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_src_acc,
  output logic [7:0] alu_ia,
  output logic [7:0] alu_ib,
  output logic [3:0] alu_func,
  input  logic [7:0] alu_oa,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       err_flag, err_flag_n;
  logic       cmd_ready_n;
  logic [7:0] ia_n, ib_n;
  logic [3:0] func_n;
  logic       rsp_valid_n;
  logic [7:0] rsp_data_n;
  logic       rsp_err_n;
  logic [7:0] a_sel;
  logic       chk_err, chk_rsvd;
  logic       accept;

`ifdef ACC_CHAIN_EN
  logic [7:0] acc, acc_n;
  logic [7:0] unused_cfg;

  assign a_sel      = cmd_src_acc ? acc : cmd_a;
  assign unused_cfg = ERR_CODE;
`else
  logic [8:0] unused_cfg;

  assign a_sel      = cmd_a;
  assign unused_cfg = {cmd_src_acc, ERR_CODE};
`endif

  assign accept = cmd_valid & cmd_ready;

  alu_err_check u_err_check (
    .op       (cmd_op),
    .a        (a_sel),
    .b        (cmd_b),
    .err      (chk_err),
    .reserved (chk_rsvd)
  );

  // The error flag comes from our own compare, never from spotting ERR_CODE on alu_oa.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    err_flag_n  = err_flag;
    ia_n        = alu_ia;
    ib_n        = alu_ib;
    func_n      = alu_func;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    rsp_err_n   = rsp_err;
`ifdef ACC_CHAIN_EN
    acc_n       = acc;
`endif

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (chk_rsvd) begin
            state_n     = ST_RESP;
            rsp_valid_n = 1'b1;
            rsp_data_n  = 8'h00;
            rsp_err_n   = 1'b1;
          end else begin
            state_n    = ST_DRIVE;
            ia_n       = a_sel;
            ib_n       = cmd_b;
            func_n     = ~cmd_op;
            err_flag_n = chk_err;
            cnt_n      = LAT_M1;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt == 4'd0) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_data_n  = alu_oa;
          rsp_err_n   = err_flag;
`ifdef ACC_CHAIN_EN
          if (!err_flag) begin
            acc_n = alu_oa;
          end
`endif
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    cmd_ready_n = (state_n == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      err_flag  <= 1'b0;
      cmd_ready <= 1'b0;
      alu_ia    <= 8'h00;
      alu_ib    <= 8'h00;
      alu_func  <= 4'hF;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
`ifdef ACC_CHAIN_EN
      acc       <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      err_flag  <= err_flag_n;
      cmd_ready <= cmd_ready_n;
      alu_ia    <= ia_n;
      alu_ib    <= ib_n;
      alu_func  <= func_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_err   <= rsp_err_n;
`ifdef ACC_CHAIN_EN
      acc       <= acc_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a behavioural ALU beside each instance (ALU_LAT 1 and 4).
module tb_alu_cmd_ctrl;
  import alu_cmd_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, cmd_ready, cmd_src_acc, rsp_valid, rsp_ready, rsp_err;
  logic [3:0] cmd_op, alu_func;
  logic [7:0] cmd_a, cmd_b, alu_ia, alu_ib, alu_oa, rsp_data;

  logic       rst_n_4, cmd_valid_4, cmd_ready_4, cmd_src_acc_4, rsp_valid_4, rsp_ready_4, rsp_err_4;
  logic [3:0] cmd_op_4, alu_func_4;
  logic [7:0] cmd_a_4, cmd_b_4, alu_ia_4, alu_ib_4, alu_oa_4, rsp_data_4;

  int vectors = 0;
  int miscompares = 0;

  // Stand-in for alu_8bit: decodes func as ~opcode and returns 0xEE on ADD overflow / SUB underflow.
  function automatic logic [7:0] aluModel(input logic [3:0] func, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] op;
    logic [8:0] sum;
    op  = ~func;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_ADD: return sum[8] ? 8'hEE : sum[7:0];
      OP_SUB: return (a < b) ? 8'hEE : a - b;
      OP_SHL: return a << b;
      OP_SHR: return a >> b;
      OP_ASR: return $unsigned($signed(a) >>> b);
      OP_XOR: return a ^ b;
      OP_EQ:  return {7'd0, a == b};
      OP_GE:  return {7'd0, a >= b};
      OP_LT:  return {7'd0, a < b};
      default: return 8'h00;
    endcase
  endfunction

  assign alu_oa   = aluModel(alu_func, alu_ia, alu_ib);
  assign alu_oa_4 = aluModel(alu_func_4, alu_ia_4, alu_ib_4);

  alu_cmd_ctrl #(.ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_src_acc(cmd_src_acc),
    .alu_ia(alu_ia), .alu_ib(alu_ib), .alu_func(alu_func), .alu_oa(alu_oa),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  alu_cmd_ctrl #(.ALU_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n_4), .cmd_valid(cmd_valid_4), .cmd_ready(cmd_ready_4),
    .cmd_op(cmd_op_4), .cmd_a(cmd_a_4), .cmd_b(cmd_b_4), .cmd_src_acc(cmd_src_acc_4),
    .alu_ia(alu_ia_4), .alu_ib(alu_ib_4), .alu_func(alu_func_4), .alu_oa(alu_oa_4),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_data(rsp_data_4), .rsp_err(rsp_err_4)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
    logic [3:0] exp_func;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One full transaction on the ALU_LAT=1 instance with rsp_ready held high.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic src, output logic [7:0] data, output logic err,
                               output int lat, output logic [3:0] func);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_src_acc = src;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    func      = alu_func;
    lat       = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    data = rsp_data;
    err  = rsp_err;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       e;
    int         l;
    logic [3:0] f;
    int         seen;

    vecs.push_back(vec_t'{OP_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1, 4'hD});
    vecs.push_back(vec_t'{OP_ADD, 8'hF0, 8'h20, 8'hEE, 1'b1, 1, 4'hD});
    vecs.push_back(vec_t'{OP_ADD, 8'h77, 8'h77, 8'hEE, 1'b0, 1, 4'hD});
    vecs.push_back(vec_t'{OP_SUB, 8'h05, 8'h09, 8'hEE, 1'b1, 1, 4'hC});
    vecs.push_back(vec_t'{4'hC,   8'h11, 8'h22, 8'h00, 1'b1, 0, 4'hC});
    vecs.push_back(vec_t'{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1, 4'hF});
    vecs.push_back(vec_t'{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1, 4'hE});
    vecs.push_back(vec_t'{OP_SHL, 8'h81, 8'h01, 8'h02, 1'b0, 1, 4'hB});
    vecs.push_back(vec_t'{OP_SHR, 8'h81, 8'h03, 8'h10, 1'b0, 1, 4'hA});
    vecs.push_back(vec_t'{OP_ASR, 8'h81, 8'h01, 8'hC0, 1'b0, 1, 4'h9});
    vecs.push_back(vec_t'{OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0, 1, 4'h8});
    vecs.push_back(vec_t'{OP_EQ,  8'h42, 8'h42, 8'h01, 1'b0, 1, 4'h7});
    vecs.push_back(vec_t'{OP_GE,  8'h05, 8'h09, 8'h00, 1'b0, 1, 4'h6});
    vecs.push_back(vec_t'{OP_LT,  8'h03, 8'h07, 8'h01, 1'b0, 1, 4'h5});
    vecs.push_back(vec_t'{OP_SHL, 8'h01, 8'h08, 8'h00, 1'b0, 1, 4'hB});
    vecs.push_back(vec_t'{OP_ASR, 8'h80, 8'h09, 8'hFF, 1'b0, 1, 4'h9});
    vecs.push_back(vec_t'{OP_SUB, 8'h09, 8'h05, 8'h04, 1'b0, 1, 4'hC});
    vecs.push_back(vec_t'{OP_ADD, 8'hFF, 8'h01, 8'hEE, 1'b1, 1, 4'hD});
    vecs.push_back(vec_t'{OP_ADD, 8'hFF, 8'h00, 8'hFF, 1'b0, 1, 4'hD});
    vecs.push_back(vec_t'{4'hF,   8'h00, 8'h00, 8'h00, 1'b1, 0, 4'hD});
    vecs.push_back(vec_t'{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1, 4'hC});

    rst_n = 1'b0;  cmd_valid = 1'b0;  cmd_op = 4'h0;  cmd_a = 8'h00;  cmd_b = 8'h00;
    cmd_src_acc = 1'b0;  rsp_ready = 1'b1;
    rst_n_4 = 1'b0;  cmd_valid_4 = 1'b0;  cmd_op_4 = 4'h0;  cmd_a_4 = 8'h00;  cmd_b_4 = 8'h00;
    cmd_src_acc_4 = 1'b0;  rsp_ready_4 = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("rst_alu_ia", {24'd0, alu_ia}, 32'h00);
    checkOutput("rst_alu_ib", {24'd0, alu_ib}, 32'h00);
    checkOutput("rst_alu_func", {28'd0, alu_func}, 32'hF);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n   = 1'b1;
    rst_n_4 = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, d, e, l, f);
      checkOutput($sformatf("v%0d_data", i), {24'd0, d}, {24'd0, vecs[i].exp_data});
      checkOutput($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      checkOutput($sformatf("v%0d_lat", i), l, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_func", i), {28'd0, f}, {28'd0, vecs[i].exp_func});
    end

    // Backpressure: LT result held while rsp_ready is low; a stray command meanwhile is ignored.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;  cmd_op = OP_LT;  cmd_a = 8'h03;  cmd_b = 8'h07;
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_ADD;  cmd_a = 8'h01;  cmd_b = 8'h01;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("bp%0d_data", k), {24'd0, rsp_data}, 32'h01);
      checkOutput($sformatf("bp%0d_ready", k), {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("bp_no_stray_rsp", seen, 0);
    checkOutput("bp_func_kept", {28'd0, alu_func}, 32'h5);

`ifdef ACC_CHAIN_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_ADD, 8'h05, 8'h03, 1'b0, d, e, l, f);
    checkOutput("acc_first", {24'd0, d}, 32'h08);
    applyStimulus(OP_ADD, 8'hFF, 8'h02, 1'b1, d, e, l, f);
    checkOutput("acc_chain", {24'd0, d}, 32'h0A);
    applyStimulus(OP_ADD, 8'h00, 8'hFF, 1'b1, d, e, l, f);
    checkOutput("acc_err_flag", {31'd0, e}, 32'd1);
    applyStimulus(4'hD, 8'h00, 8'h00, 1'b1, d, e, l, f);
    checkOutput("acc_rsvd_err", {31'd0, e}, 32'd1);
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b1, d, e, l, f);
    checkOutput("acc_kept", {24'd0, d}, 32'h0A);
`else
    applyStimulus(OP_ADD, 8'h01, 8'h02, 1'b1, d, e, l, f);
    checkOutput("src_acc_ignored", {24'd0, d}, 32'h03);
`endif

    // ALU_LAT=4 instance: normal latency, then reset in the middle of DRIVE.
    cmd_valid_4 = 1'b1;  cmd_op_4 = OP_ADD;  cmd_a_4 = 8'h10;  cmd_b_4 = 8'h20;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_4 = 1'b0;
    l = 0;
    while (!rsp_valid_4 && l < 40) begin
      @(negedge clk);
      l++;
    end
    checkOutput("lat4_latency", l, 4);
    checkOutput("lat4_data", {24'd0, rsp_data_4}, 32'h30);
    @(negedge clk);
    seen = 0;
    while (!cmd_ready_4 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    cmd_valid_4 = 1'b1;  cmd_op_4 = OP_SUB;  cmd_a_4 = 8'h09;  cmd_b_4 = 8'h05;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_4 = 1'b0;
    @(negedge clk);
    rst_n_4 = 1'b0;
    @(negedge clk);
    rst_n_4 = 1'b1;
    checkOutput("mid_rst_cmd_ready", {31'd0, cmd_ready_4}, 32'd0);
    checkOutput("mid_rst_alu_ia", {24'd0, alu_ia_4}, 32'h00);
    checkOutput("mid_rst_alu_ib", {24'd0, alu_ib_4}, 32'h00);
    checkOutput("mid_rst_alu_func", {28'd0, alu_func_4}, 32'hF);
    checkOutput("mid_rst_rsp_valid", {31'd0, rsp_valid_4}, 32'd0);
    checkOutput("mid_rst_rsp_data", {24'd0, rsp_data_4}, 32'h00);
    checkOutput("mid_rst_rsp_err", {31'd0, rsp_err_4}, 32'd0);
    @(negedge clk);
    checkOutput("mid_rst_ready_back", {31'd0, cmd_ready_4}, 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid_4) seen++;
    end
    checkOutput("mid_rst_no_rsp", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
